btb_update_ctrl: RTL

Write-side controller for the direct-mapped branch target buffer. It accepts branch resolutions from the EX stage and filters out those that need no BTB change. Surviving updates are buffered in a small FIFO and issued to the BTB write port at one per cycle. A flush request triggers a sweep that invalidates every BTB entry by writing a zero state bit to each index.

---
 rtl/btb_update_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/btb_update_ctrl.sv
// BTB write-side controller: filters EX branch resolutions, queues needed updates
// in a small FIFO, drains one write per cycle, and sweeps the BTB clear on flush.
module btb_update_ctrl #(
  parameter int BUFFER_ADDR_LEN = 12,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_predicted,
  input  logic [31:0] ex_predicted_pc,
  input  logic        flush_req,
  output logic        flush_busy,
  output logic        btb_wr_req,
  output logic [31:0] btb_wr_PC,
  output logic [31:0] btb_wr_predicted_PC,
  output logic        btb_wr_predicted_state_bit,
  output logic [31:0] mispredict_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = BUFFER_ADDR_LEN + 1;
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(1) << BUFFER_ADDR_LEN;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [31:0]        fifo_pc  [FIFO_DEPTH];
  logic [31:0]        fifo_tgt [FIFO_DEPTH];
  logic               fifo_bit [FIFO_DEPTH];

  logic        fifo_full, fifo_empty, need_write, push, pop;
  logic        wr_req_next, wr_bit_next;
  logic [31:0] wr_pc_next, wr_tgt_next, sweep_pc;

  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign ex_ready   = !rst && (state_reg == IDLE) && !fifo_full && !flush_req;
  assign need_write = ex_is_branch &&
                      ((ex_taken != ex_predicted) || (ex_taken && (ex_target != ex_predicted_pc)));
  assign push       = ex_valid && ex_ready && need_write;
  // A flush discards the queue, so nothing is popped on that edge.
  assign pop        = (state_reg == IDLE) && !fifo_empty && !flush_req;
  assign sweep_pc   = {{(30-BUFFER_ADDR_LEN){1'b0}}, idx_reg[BUFFER_ADDR_LEN-1:0], 2'b00};
  assign flush_busy = (state_reg == SWEEP);

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    wr_req_next = 1'b0;
    wr_pc_next  = btb_wr_PC;
    wr_tgt_next = btb_wr_predicted_PC;
    wr_bit_next = btb_wr_predicted_state_bit;
    if (flush_req) begin
      // Index 0 is written on the flush edge itself; the sweep continues from 1.
      state_next  = SWEEP;
      idx_next    = IDX_W'(1);
      wr_req_next = 1'b1;
      wr_pc_next  = 32'd0;
      wr_tgt_next = 32'd0;
      wr_bit_next = 1'b0;
    end else if (state_reg == SWEEP) begin
      if (idx_reg == IDX_END) begin
        state_next = IDLE;
      end else begin
        wr_req_next = 1'b1;
        wr_pc_next  = sweep_pc;
        wr_tgt_next = 32'd0;
        wr_bit_next = 1'b0;
        idx_next    = idx_reg + IDX_W'(1);
      end
    end else if (!fifo_empty) begin
      wr_req_next = 1'b1;
      wr_pc_next  = fifo_pc[rd_ptr_reg];
      wr_tgt_next = fifo_tgt[rd_ptr_reg];
      wr_bit_next = fifo_bit[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg                  <= IDLE;
      idx_reg                    <= '0;
      btb_wr_req                 <= 1'b0;
      btb_wr_PC                  <= 32'd0;
      btb_wr_predicted_PC        <= 32'd0;
      btb_wr_predicted_state_bit <= 1'b0;
    end else begin
      state_reg                  <= state_next;
      idx_reg                    <= idx_next;
      btb_wr_req                 <= wr_req_next;
      btb_wr_PC                  <= wr_pc_next;
      btb_wr_predicted_PC        <= wr_tgt_next;
      btb_wr_predicted_state_bit <= wr_bit_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush_req) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_reg]  <= ex_pc;
      fifo_tgt[wr_ptr_reg] <= ex_target;
      fifo_bit[wr_ptr_reg] <= ex_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       mispredict_cnt <= 32'd0;
    else if (push) mispredict_cnt <= mispredict_cnt + 32'd1;
  end
endmodule
